// File: rtl/fifo_wpack.sv
// fifo_wpack: pops WIDTH-bit entries from a show-ahead FIFO and packs NBYTE of
// them (first popped in the LSBs) into one word presented on a valid/ready
// output. A flush pulse pushes out a partial word together with its entry count.
module fifo_wpack #(
  parameter int WIDTH  = 8,
  parameter int NBYTE  = 4,
  parameter int CNTBIT = 2
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   fifo_notempty,
  input  logic [WIDTH-1:0]       fifo_dout,
  output logic                   fifo_rd,
  input  logic                   flush,
  output logic                   word_vld,
  input  logic                   word_rdy,
  output logic [WIDTH*NBYTE-1:0] word_dat,
  output logic [CNTBIT:0]        word_len,
  output logic                   busy
);

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [CNTBIT:0] CNT_FULL = (CNTBIT+1)'(NBYTE);
  localparam logic [CNTBIT:0] CNT_ONE  = (CNTBIT+1)'(1);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       acc_q [NBYTE];
  logic [WIDTH-1:0]       acc_d [NBYTE];
  logic [CNTBIT:0]        acccnt_q, acccnt_d;
  logic [WIDTH*NBYTE-1:0] word_dat_q, word_dat_d;
  logic [CNTBIT:0]        word_len_q, word_len_d;
  logic                   word_vld_q, word_vld_d;

  logic                   ofree;
  logic                   acc_full;
  logic                   xfer;
  logic                   pop;
  logic [CNTBIT-1:0]      wr_idx;
  logic [WIDTH*NBYTE-1:0] packed_word;

  // Handshake decisions: when the output register can take a word, and when to pop.
  always_comb begin
    ofree    = !word_vld_q || word_rdy;
    acc_full = (acccnt_q == CNT_FULL);
    xfer     = ofree && (acc_full || ((state_q == ST_FLUSH) && (acccnt_q != '0)));
    // A full accumulator still accepts a pop in the cycle its word moves out,
    // which is what sustains one entry per cycle.
    pop      = rst_ && (state_q == ST_FILL) && fifo_notempty && (!acc_full || xfer);
  end

  // Accumulator image with the unfilled slots zeroed, ready to load into the output register.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    packed_word = '0;
    for (int k = 0; k < NBYTE; k++) begin
      if ((CNTBIT+1)'(k) < acccnt_q) begin
        packed_word[k*WIDTH +: WIDTH] = acc_q[k];
      end
    end
  end

  // Accumulator write and fill count.
  always_comb begin
    acc_d    = acc_q;
    acccnt_d = acccnt_q;
    // On a transfer the new entry starts the next word in slot 0.
    wr_idx   = xfer ? '0 : acccnt_q[CNTBIT-1:0];
    if (pop) begin
      acc_d[wr_idx] = fifo_dout;
    end
    if (xfer) begin
      acccnt_d = pop ? CNT_ONE : '0;
    end else if (pop) begin
      acccnt_d = acccnt_q + CNT_ONE;
    end
  end

  // Output register: load on transfer, retire once the consumer has taken the word.
  always_comb begin
    word_dat_d = word_dat_q;
    word_len_d = word_len_q;
    word_vld_d = word_vld_q;
    if (xfer) begin
      word_dat_d = packed_word;
      word_len_d = acccnt_q;
      word_vld_d = 1'b1;
    end else if (ofree) begin
      word_vld_d = 1'b0;
    end
  end

  // FILL/FLUSH next-state: flush closes the current word, FLUSH leaves once it is out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if ((acccnt_q == '0) || xfer) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // State register; reset discards any partial word and the pending output.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= ST_FILL;
      // NOTE: the accumulator array is cleared on reset as well, so that stale
      // entries can never appear in a word after reset.
      acc_q      <= '{default: '0};
      acccnt_q   <= '0;
      word_dat_q <= '0;
      word_len_q <= '0;
      word_vld_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      acc_q      <= acc_d;
      acccnt_q   <= acccnt_d;
      word_dat_q <= word_dat_d;
      word_len_q <= word_len_d;
      word_vld_q <= word_vld_d;
    end
  end

  assign fifo_rd  = pop;
  assign word_vld = word_vld_q;
  assign word_dat = word_dat_q;
  assign word_len = word_len_q;
  assign busy     = (acccnt_q != '0) || (state_q == ST_FLUSH) || word_vld_q;

endmodule

// File: tb/tb_fifo_wpack.sv
// Testbench for fifo_wpack: a show-ahead source queue feeds the DUT, a per-cycle
// engine records pops, flushes and accepted words, and each test compares the
// records against constants or a queue-based packing model.
module tb_fifo_wpack;
  localparam int WIDTH  = 8;
  localparam int NBYTE  = 4;
  localparam int CNTBIT = 2;
  localparam int WW     = WIDTH * NBYTE;

  logic              clk = 1'b0;
  logic              rst_ = 1'b1;
  logic              fifo_notempty = 1'b0;
  logic [WIDTH-1:0]  fifo_dout = '0;
  logic              fifo_rd;
  logic              flush = 1'b0;
  logic              word_vld;
  logic              word_rdy = 1'b0;
  logic [WW-1:0]     word_dat;
  logic [CNTBIT:0]   word_len;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  // Stimulus controls
  logic [WIDTH-1:0] src_q[$];
  bit src_en    = 1'b1;
  bit rdy_rand  = 1'b0;
  bit rdy_fixed = 1'b1;
  bit flush_req = 1'b0;

  // Observation records
  logic [WIDTH-1:0] pop_log[$];
  int               flush_log[$];
  bit               rd_trace[$];
  bit               vld_trace[$];
  logic [WW-1:0]    obs_dat[$];
  logic [CNTBIT:0]  obs_len[$];
  logic [WW-1:0]    exp_dat[$];
  logic [CNTBIT:0]  exp_len[$];
  int               stab_err = 0;
  int               empty_pop_err = 0;
  bit               prev_stall = 1'b0;
  logic [WW-1:0]    prev_dat = '0;
  logic [CNTBIT:0]  prev_len = '0;

  always #5 clk = ~clk;

  fifo_wpack #(.WIDTH(WIDTH), .NBYTE(NBYTE), .CNTBIT(CNTBIT)) dut (
    .clk           (clk),
    .rst_          (rst_),
    .fifo_notempty (fifo_notempty),
    .fifo_dout     (fifo_dout),
    .fifo_rd       (fifo_rd),
    .flush         (flush),
    .word_vld      (word_vld),
    .word_rdy      (word_rdy),
    .word_dat      (word_dat),
    .word_len      (word_len),
    .busy          (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    pop_log.delete(); flush_log.delete(); rd_trace.delete(); vld_trace.delete();
    obs_dat.delete(); obs_len.delete(); exp_dat.delete(); exp_len.delete();
    stab_err = 0; empty_pop_err = 0; prev_stall = 1'b0;
  endtask

  // One clock cycle: drive inputs on the falling edge, then record what the DUT
  // will do at the coming rising edge.
  task automatic tick();
    @(negedge clk);
    fifo_notempty = src_en && (src_q.size() != 0);
    fifo_dout     = fifo_notempty ? src_q[0] : WIDTH'($urandom);
    flush         = flush_req;
    flush_req     = 1'b0;
    word_rdy      = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    #1;
    rd_trace.push_back(fifo_rd === 1'b1);
    vld_trace.push_back(word_vld === 1'b1);
    if (fifo_rd === 1'b1) begin
      if (!fifo_notempty) empty_pop_err++;
      else begin
        pop_log.push_back(fifo_dout);
        void'(src_q.pop_front());
      end
    end
    if (flush) flush_log.push_back(pop_log.size());
    if (prev_stall && (word_vld !== 1'b1 || word_dat !== prev_dat || word_len !== prev_len))
      stab_err++;
    prev_stall = (word_vld === 1'b1) && !word_rdy;
    prev_dat   = word_dat;
    prev_len   = word_len;
    if (word_vld === 1'b1 && word_rdy) begin
      obs_dat.push_back(word_dat);
      obs_len.push_back(word_len);
    end
  endtask

  // Packing model: popped entries are grouped NBYTE at a time in pop order; a
  // flush closes the open group (including a pop in the flush cycle itself).
  function automatic void build_expected();
    logic [WW-1:0] w;
    int cnt;
    int fi;
    exp_dat.delete(); exp_len.delete();
    w = '0; cnt = 0; fi = 0;
    for (int i = 0; i <= pop_log.size(); i++) begin
      if (i > 0) begin
        w[cnt*WIDTH +: WIDTH] = pop_log[i-1];
        cnt++;
        if (cnt == NBYTE) begin
          exp_dat.push_back(w); exp_len.push_back((CNTBIT+1)'(cnt));
          w = '0; cnt = 0;
        end
      end
      while (fi < flush_log.size() && flush_log[fi] == i) begin
        if (cnt != 0) begin
          exp_dat.push_back(w); exp_len.push_back((CNTBIT+1)'(cnt));
          w = '0; cnt = 0;
        end
        fi++;
      end
    end
  endfunction

  task automatic test_reset();
    fifo_notempty = 1'b1;
    fifo_dout     = 8'hAA;
    #2 rst_ = 1'b0;
    #1;
    checks++;
    if ({fifo_rd, word_vld, word_dat, word_len, busy} !== {1'b0, 1'b0, {WW{1'b0}}, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got rd=%b vld=%b dat=%h len=%0d busy=%b exp all zero",
               fifo_rd, word_vld, word_dat, word_len, busy);
    end
    fifo_notempty = 1'b0;
    @(negedge clk);
    #3 rst_ = 1'b1;
  endtask

  task automatic test_stream();
    int ones;
    int first;
    int last;
    clear_logs();
    rdy_fixed = 1'b1;
    for (int i = 1; i <= 8; i++) src_q.push_back(WIDTH'(i));
    repeat (14) tick();
    ones = 0; first = -1; last = -1;
    foreach (rd_trace[i]) if (rd_trace[i]) begin
      ones++; if (first < 0) first = i; last = i;
    end
    checks++;
    if (ones != 8 || last - first != 7) begin
      failures++;
      $display("FAIL stream_rd_run got ones=%0d span=%0d exp ones=8 span=7", ones, last - first);
    end
    checks++;
    if (obs_dat.size() != 2) begin
      failures++;
      $display("FAIL stream_word_count got=%0d exp=2", obs_dat.size());
    end else begin
      checks++;
      if (obs_dat[0] !== 32'h04030201 || obs_len[0] !== 3'd4) begin
        failures++;
        $display("FAIL stream_word0 got=%h/%0d exp=04030201/4", obs_dat[0], obs_len[0]);
      end
      checks++;
      if (obs_dat[1] !== 32'h08070605 || obs_len[1] !== 3'd4) begin
        failures++;
        $display("FAIL stream_word1 got=%h/%0d exp=08070605/4", obs_dat[1], obs_len[1]);
      end
    end
  endtask

  task automatic test_flush_partial();
    clear_logs();
    src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
    repeat (4) tick();
    flush_req = 1'b1;
    repeat (6) tick();
    checks++;
    if (obs_dat.size() != 1) begin
      failures++;
      $display("FAIL flush_word_count got=%0d exp=1", obs_dat.size());
    end else begin
      checks++;
      if (obs_dat[0] !== 32'h00332211 || obs_len[0] !== 3'd3) begin
        failures++;
        $display("FAIL flush_partial_word got=%h/%0d exp=00332211/3", obs_dat[0], obs_len[0]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy_after got=%b exp=0", busy);
    end
  endtask

  task automatic test_flush_empty();
    clear_logs();
    flush_req = 1'b1;
    tick();
    src_q.push_back(8'hA1); src_q.push_back(8'hA2); src_q.push_back(8'hA3); src_q.push_back(8'hA4);
    repeat (10) tick();
    checks++;
    if (rd_trace[1] !== 1'b0 || rd_trace[2] !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty_resume got rd[1]=%b rd[2]=%b exp 0,1", rd_trace[1], rd_trace[2]);
    end
    checks++;
    if (vld_trace[0] || vld_trace[1] || obs_dat.size() != 1) begin
      failures++;
      $display("FAIL flush_empty_noword got vld0=%b vld1=%b words=%0d exp 0,0,1",
               vld_trace[0], vld_trace[1], obs_dat.size());
    end else begin
      checks++;
      if (obs_dat[0] !== 32'hA4A3A2A1 || obs_len[0] !== 3'd4) begin
        failures++;
        $display("FAIL flush_empty_word got=%h/%0d exp=a4a3a2a1/4", obs_dat[0], obs_len[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] ent[12];
    int ones;
    logic [WW-1:0] w;
    clear_logs();
    rdy_fixed = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ent[i] = WIDTH'($urandom);
      src_q.push_back(ent[i]);
    end
    repeat (14) tick();
    ones = 0;
    foreach (rd_trace[i]) if (rd_trace[i]) ones++;
    checks++;
    if (ones != 8 || rd_trace[7] !== 1'b1 || rd_trace[8] !== 1'b0) begin
      failures++;
      $display("FAIL bp_pop_stall got pops=%0d rd7=%b rd8=%b exp 8,1,0", ones, rd_trace[7], rd_trace[8]);
    end
    w = {ent[3], ent[2], ent[1], ent[0]};
    checks++;
    if (word_vld !== 1'b1 || word_dat !== w || word_len !== 3'd4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_held_word got vld=%b dat=%h len=%0d busy=%b exp 1 %h 4 1",
               word_vld, word_dat, word_len, busy, w);
    end
    rdy_fixed = 1'b1;
    repeat (12) tick();
    checks++;
    if (obs_dat.size() != 3) begin
      failures++;
      $display("FAIL bp_drain_count got=%0d exp=3", obs_dat.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        w = {ent[4*k+3], ent[4*k+2], ent[4*k+1], ent[4*k]};
        checks++;
        if (obs_dat[k] !== w || obs_len[k] !== 3'd4) begin
          failures++;
          $display("FAIL bp_drain_word%0d got=%h/%0d exp=%h/4", k, obs_dat[k], obs_len[k], w);
        end
      end
    end
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL bp_stability got=%0d unstable cycles exp=0", stab_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ent[16];
    int ones;
    int vidx[$];
    logic [WW-1:0] w;
    clear_logs();
    rdy_fixed = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ent[i] = WIDTH'($urandom);
      src_q.push_back(ent[i]);
    end
    repeat (22) tick();
    ones = 0;
    for (int i = 0; i < 16; i++) if (rd_trace[i]) ones++;
    checks++;
    if (ones != 16) begin
      failures++;
      $display("FAIL b2b_no_bubble got=%0d pops in first 16 cycles exp=16", ones);
    end
    foreach (vld_trace[i]) if (vld_trace[i]) vidx.push_back(i);
    checks++;
    if (vidx.size() != 4 || vidx[0] != 5 || vidx[1] != 9 || vidx[2] != 13 || vidx[3] != 17) begin
      failures++;
      $display("FAIL b2b_vld_spacing got count=%0d first=%0d exp 4 pulses at 5,9,13,17",
               vidx.size(), (vidx.size() > 0) ? vidx[0] : -1);
    end
    checks++;
    if (obs_dat.size() != 4) begin
      failures++;
      $display("FAIL b2b_word_count got=%0d exp=4", obs_dat.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        w = {ent[4*k+3], ent[4*k+2], ent[4*k+1], ent[4*k]};
        checks++;
        if (obs_dat[k] !== w) begin
          failures++;
          $display("FAIL b2b_word%0d got=%h exp=%h", k, obs_dat[k], w);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    rdy_fixed = 1'b1;
    src_q.push_back(8'h55); src_q.push_back(8'h66);
    src_q.push_back(8'hE1); src_q.push_back(8'hE2); src_q.push_back(8'hE3); src_q.push_back(8'hE4);
    repeat (2) tick();
    #2 rst_ = 1'b0;
    #1;
    checks++;
    if ({fifo_rd, word_vld, word_dat, word_len, busy} !== {1'b0, 1'b0, {WW{1'b0}}, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_outputs got rd=%b vld=%b dat=%h len=%0d busy=%b exp all zero",
               fifo_rd, word_vld, word_dat, word_len, busy);
    end
    #4 rst_ = 1'b1;
    clear_logs();
    repeat (10) tick();
    checks++;
    if (obs_dat.size() != 1 || obs_dat[0] !== 32'hE4E3E2E1 || obs_len[0] !== 3'd4) begin
      failures++;
      $display("FAIL midreset_clean_word got count=%0d word=%h exp 1 word e4e3e2e1/4",
               obs_dat.size(), (obs_dat.size() > 0) ? obs_dat[0] : '0);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] src_ref[$];
    int since_flush;
    int n;
    clear_logs();
    for (int i = 0; i < 150; i++) begin
      src_ref.push_back(WIDTH'($urandom));
      src_q.push_back(src_ref[i]);
    end
    rdy_rand = 1'b1;
    since_flush = 2;
    for (int c = 0; c < 400; c++) begin
      src_en = ($urandom_range(0, 9) < 7);
      build_expected();
      // Flush only when every closed word has left, so the DUT is known to be in FILL.
      if (since_flush >= 2 && exp_dat.size() == obs_dat.size() && $urandom_range(0, 19) == 0) begin
        flush_req = 1'b1;
        since_flush = 0;
      end else begin
        since_flush++;
      end
      tick();
    end
    src_en = 1'b1; rdy_rand = 1'b0; rdy_fixed = 1'b1;
    for (int c = 0; c < 200 && src_q.size() != 0; c++) tick();
    repeat (6) tick();
    flush_req = 1'b1;
    repeat (8) tick();
    build_expected();
    checks++;
    if (pop_log.size() != src_ref.size()) begin
      failures++;
      $display("FAIL rand_pop_count got=%0d exp=%0d", pop_log.size(), src_ref.size());
    end
    checks++;
    if (exp_dat.size() != obs_dat.size()) begin
      failures++;
      $display("FAIL rand_word_count got=%0d exp=%0d", obs_dat.size(), exp_dat.size());
    end
    n = (exp_dat.size() < obs_dat.size()) ? exp_dat.size() : obs_dat.size();
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs_dat[k] !== exp_dat[k] || obs_len[k] !== exp_len[k]) begin
        failures++;
        $display("FAIL rand_word%0d got=%h/%0d exp=%h/%0d", k, obs_dat[k], obs_len[k], exp_dat[k], exp_len[k]);
      end
    end
    checks++;
    if (stab_err != 0 || empty_pop_err != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rand_protocol got unstable=%0d empty_pops=%0d busy=%b exp 0 0 0",
               stab_err, empty_pop_err, busy);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_flush_partial();
    test_flush_empty();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wpack.md
Name: fifo_wpack

Overview:
- Downstream consumer of the project's show-ahead register FIFO (data valid whenever not-empty; read pops the entry).
- Pops WIDTH-bit entries and packs NBYTE of them, first-popped in the LSBs, into one output word.
- Presents the word on a valid/ready interface to the next datapath stage (e.g. the coefficient bus).
- A flush pulse emits a partial word together with its valid-entry count.

Parameters:
WIDTH, 8, width of one FIFO entry
NBYTE, 4, entries per packed word (power of 2, >=2)
CNTBIT, 2, log2(NBYTE)

Ports:
clk  input  1  clock, rising edge
rst_  input  1  asynchronous active-low reset
fifo_notempty  input  1  upstream FIFO not-empty
fifo_dout  input  WIDTH  upstream FIFO head data, valid while fifo_notempty
fifo_rd  output  1  pop strobe to upstream FIFO (combinational)
flush  input  1  single-cycle request to emit the accumulated partial word
word_vld  output  1  output word valid
word_rdy  input  1  downstream accepts word when word_vld && word_rdy
word_dat  output  WIDTH*NBYTE  packed word; entry k at bits [k*WIDTH +: WIDTH]
word_len  output  CNTBIT+1  number of valid entries in word_dat (1..NBYTE)
busy  output  1  accumulator non-empty, flush pending, or word_vld

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_). Reset clears all registers; word_vld=0, word_dat=0, word_len=0, busy=0; state FILL. fifo_rd is 0 while rst_ is low.
- Storage: accumulator acc[NBYTE], acccnt (CNTBIT+1 bits, 0..NBYTE); output register word_dat/word_len/word_vld.
- Output register free: ofree = !word_vld || word_rdy.
- Transfer condition: xfer = ofree && (acccnt==NBYTE || (state==FLUSH && acccnt!=0)).
- Transfer action:
  - word_dat <= acc, with entries at index >= acccnt forced to 0; word_len <= acccnt; word_vld <= 1.
  - acccnt <= 0, or 1 if a pop occurs in the same cycle.
- When ofree and !xfer: word_vld <= 0.
- State FILL:
  - fifo_rd = fifo_notempty && (acccnt<NBYTE || xfer).
  - On a pop, acc[idx] <= fifo_dout, where idx = acccnt, or 0 if xfer.
  - acccnt increments, unless xfer occurs in the same cycle.
- flush in FILL goes to FLUSH; a pop in the flush cycle itself is still taken and counted.
- State FLUSH:
  - fifo_rd = 0.
  - If acccnt==0, return to FILL next cycle with no word emitted.
  - Otherwise wait for xfer, then return to FILL.
  - flush in FLUSH is ignored.
- Latency: last entry popped at cycle t; acccnt==NBYTE at t+1; word_vld=1 at t+2 if the output register is free.
- Throughput: sustained 1 entry/cycle when fifo_notempty and word_rdy are held high.
- Backpressure:
  - word_vld, word_dat and word_len are stable while word_vld && !word_rdy.
  - The accumulator may fill to NBYTE and then stalls pops.
- Never pop while fifo_notempty=0. fifo_dout is sampled only on a pop cycle.
- busy = (acccnt!=0) || (state==FLUSH) || word_vld.
- Async reset mid-word discards the accumulator and the output word.

Test Plan:
- Reset then 8 FIFO entries 0x01..0x08, word_rdy=1 -> word_dat=0x04030201 (len 4), then 0x08070605 (len 4); fifo_rd high 8 consecutive cycles.
- Entries 0x11,0x22,0x33 then flush pulse -> one word 0x00332211, word_len=3; busy=0 afterwards.
- flush with acccnt=0 -> no word_vld; state returns to FILL after 1 cycle; pops resume.
- word_rdy=0 with 12 entries available -> first word held stable; accumulator fills to 4; fifo_rd drops after 8 pops; raising word_rdy drains both words in order with no entry loss.
- Continuous stream of 16 entries, word_rdy=1 -> 4 words with no bubble in fifo_rd; word_vld pulses every 4 cycles.
- Assert rst_ low after 2 entries popped -> all outputs 0 immediately; after release, next 4 entries form a clean word 0x(e4e3e2e1).
